axi_fifo_wr_arbiter: RTL and testbench
======================================

// Module: axi_fifo_wr_arbiter
// PURPOSE
//   Shares one FIFO write port (the write side driven by an AXI-to-FIFO bridge) among N_CH
//   requesters.
//   Round-robin grant with a bounded burst per grant, plus zero-latency data passthrough.
//   Back-pressures requesters on fifo_full and tags every written word with its source channel.
//   Sits between per-channel producers (AXI bridges, sequencers) and a shared command/data FIFO.
// PARAMETERS
//   N_CH        4   number of requesters (2..16)
//   DATA_WIDTH  32  word width, both sides
//   BURST_LEN   4   max words accepted per grant before forced re-arbitration (>=1)
//   CH_W        $clog2(N_CH)  channel index width (derived; do not override)
// PORTS
//   aclk          in   1              clock
//   aresetn       in   1              synchronous active-low reset
//   s_valid       in   N_CH           per-channel word valid
//   s_data        in   N_CH*DATA_WIDTH  per-channel word; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_ready       out  N_CH           per-channel accept; one-hot or zero
//   fifo_wr_data  out  DATA_WIDTH     word to shared FIFO
//   fifo_wr_en    out  1              write strobe to shared FIFO
//   fifo_wr_ch    out  CH_W           source channel of the current fifo_wr_en word
//   fifo_full     in   1              shared FIFO full
//   busy          out  1              high while in GRANT
//   grant_ch      out  CH_W           currently granted channel (valid when busy)
// BEHAVIOUR
//   Reset (aresetn=0 at posedge): state=IDLE, rr_ptr=0, burst_cnt=0, grant_ch=0, busy=0.
//     s_ready, fifo_wr_en, fifo_wr_data and fifo_wr_ch evaluate to 0 while in IDLE.
//   State machine: two states, IDLE and GRANT.
//   IDLE:
//     - If s_valid is nonzero: pick the first set bit at or after rr_ptr, searching upward
//       and wrapping N_CH-1 -> 0.
//     - Register that index into grant_ch, clear burst_cnt, go to GRANT.
//     - No word is accepted in IDLE, so each grant starts with a 1-cycle bubble.
//   GRANT (g = grant_ch):
//     - s_ready[g] = !fifo_full. All other s_ready bits are 0.
//     - fifo_wr_en = s_valid[g] && !fifo_full (combinational, zero latency).
//     - fifo_wr_data = s_data[g]. fifo_wr_ch = g.
//     - On accept: burst_cnt += 1.
//         If burst_cnt reaches BURST_LEN: go to IDLE, rr_ptr = (g+1) mod N_CH.
//     - s_valid[g]=0 (requester idle): go to IDLE, rr_ptr = (g+1) mod N_CH.
//       A grant is never held for an idle channel.
//     - fifo_full=1 with s_valid[g]=1: stay in GRANT, no accept, burst_cnt unchanged.
//       No word is dropped and no error is flagged; requesters see plain back-pressure.
//   Requester handshake rules:
//     - A requester holds s_valid and s_data stable until s_ready is seen.
//     - A requester may drop s_valid only when it has nothing further to send.
//   Throughput: up to BURST_LEN words per BURST_LEN+1 cycles per grant.
//   Fairness: worst-case wait for a requesting channel is (N_CH-1)*(BURST_LEN+1) cycles,
//     excluding fifo_full stall cycles.
//   rr_ptr wraps modulo N_CH. For non-power-of-2 N_CH, indices >= N_CH never occur.
//   Simultaneous events:
//     - Accept of the BURST_LEN-th word while other channels request: IDLE next cycle,
//       then those channels are granted in round-robin order.
//     - fifo_full rising in the same cycle as s_valid: no write occurs in that cycle.
//   Reset mid-burst: immediate return to reset state.
//     Words already accepted are in the FIFO. The word presented in the reset cycle is
//     not written.
// STRUCTURE
//   Package axi_fifo_arb_pkg holds:
//     - state encoding localparams ST_IDLE=1'b0, ST_GRANT=1'b1
//     - burst counter width rule: $clog2(BURST_LEN+1)
//   Sub-module rr_priority_pick #(N_CH):
//     - combinational; inputs req[N_CH] and ptr[CH_W]
//     - outputs found and idx[CH_W] (first set bit at or after ptr, with wrap)
//   Top holds the FSM, counters, output muxing and the s_data slice select.
// TESTING (N_CH=4, BURST_LEN=4, fifo_full=0 unless stated)
//   1. ch0 sends 5 words A0..A4 back-to-back ->
//        writes A0-A3 with fifo_wr_ch=0, one IDLE bubble, re-grant ch0, A4 written.
//        Total 7 cycles from first valid.
//   2. ch1 and ch3 both streaming, rr_ptr=0 ->
//        4 words ch1, 4 words ch3, 4 words ch1, ...
//        fifo_wr_ch pattern 1,1,1,1,3,3,3,3; s_ready never two-hot.
//   3. ch2 granted, fifo_full=1 for 3 cycles after its 2nd word ->
//        no fifo_wr_en and s_ready[2]=0 for those 3 cycles; burst resumes at word 3.
//        Exactly 4 words in the grant, none lost or duplicated.
//   4. ch0 granted, drops s_valid after 2 words while ch1 is waiting ->
//        IDLE next cycle, ch1 granted the cycle after; rr_ptr=1.
//   5. Only ch3 then ch0 request ->
//        ch3 granted first, rr_ptr wraps to 0, then ch0 is granted.
//   6. aresetn=0 mid-burst on ch1 word 2 ->
//        all outputs 0 next cycle, rr_ptr=0; after release ch0 wins if ch0 and ch1 both request.
//   Scoreboard: compare the per-channel written sequence to the sent sequence across
//     randomized valid/full patterns.

Source files
------------

// File: rtl/axi_fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding and the
// sizing rule for the per-grant burst counter.
package axi_fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   // Counter must hold 0..BURST_LEN inclusive.
   function automatic int burst_cnt_width(input int burst_len);
      return $clog2(burst_len + 1);
   endfunction

endpackage

// File: rtl/axi_fifo_wr_arbiter_rr_pick.sv
// Round-robin priority picker: finds the first asserted request at or after ptr,
// searching upward and wrapping from N_CH-1 back to 0. Purely combinational.
module rr_priority_pick #(
   parameter  int N_CH = 4,
   localparam int CH_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [CH_W-1:0] ptr,
   output logic            found,
   output logic [CH_W-1:0] idx
);

   // ptr is always < N_CH, so a single conditional subtract handles the wrap.
   function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N_CH) s = s - N_CH;
      return CH_W'(s);
   endfunction

   // Scan from the farthest offset down so the nearest request to ptr wins last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (req[wrap_add(ptr, i)]) begin
            found = 1'b1;
            idx   = wrap_add(ptr, i);
         end
      end
   end

endmodule

// File: rtl/axi_fifo_wr_arbiter.sv
// Shares one FIFO write port among N_CH requesters. Round-robin grant, at most
// BURST_LEN words per grant, zero-latency data passthrough while granted, and a
// channel tag on every written word. fifo_full is plain back-pressure.
module axi_fifo_wr_arbiter
   import axi_fifo_arb_pkg::*;
#(
   parameter  int N_CH       = 4,
   parameter  int DATA_WIDTH = 32,
   parameter  int BURST_LEN  = 4,
   localparam int CH_W       = $clog2(N_CH)
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [N_CH-1:0]            s_valid,
   input  logic [N_CH*DATA_WIDTH-1:0] s_data,
   output logic [N_CH-1:0]            s_ready,
   output logic [DATA_WIDTH-1:0]      fifo_wr_data,
   output logic                       fifo_wr_en,
   output logic [CH_W-1:0]            fifo_wr_ch,
   input  logic                       fifo_full,
   output logic                       busy,
   output logic [CH_W-1:0]            grant_ch
);

   localparam int BCW = burst_cnt_width(BURST_LEN);

   arb_state_e                state;
   logic [CH_W-1:0]           rr_ptr;
   logic [BCW-1:0]            burst_cnt;
   logic                      pick_found;
   logic [CH_W-1:0]           pick_idx;
   logic                      granted;
   logic                      g_valid;
   logic [DATA_WIDTH-1:0]     g_data;
   logic                      accept;
   logic                      burst_done;
   logic [CH_W-1:0]           next_ptr;

   rr_priority_pick #(.N_CH(N_CH)) u_pick (
      .req   (s_valid),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Output path is gated by aresetn so the word presented in a reset cycle is never written.
   assign granted    = (state == ST_GRANT) && aresetn;
   assign accept     = granted && g_valid && !fifo_full;
   assign burst_done = (burst_cnt == BCW'(BURST_LEN - 1));
   assign next_ptr   = (grant_ch == CH_W'(N_CH - 1)) ? '0 : grant_ch + 1'b1;

   // Select the granted channel's valid and data word.
   always_comb begin
      g_valid = s_valid[grant_ch];
      g_data  = s_data[int'(grant_ch) * DATA_WIDTH +: DATA_WIDTH];
   end

   // Passthrough to the FIFO; everything reads zero outside an active grant.
   always_comb begin
      s_ready      = '0;
      fifo_wr_en   = 1'b0;
      fifo_wr_data = '0;
      fifo_wr_ch   = '0;
      if (granted) begin
         s_ready[grant_ch] = !fifo_full;
         fifo_wr_en        = accept;
         fifo_wr_data      = g_data;
         fifo_wr_ch        = grant_ch;
      end
   end

   // Arbitration FSM: pick in IDLE (one-cycle bubble), stream in GRANT until burst end or idle requester.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         burst_cnt <= '0;
         grant_ch  <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  state     <= ST_GRANT;
                  grant_ch  <= pick_idx;
                  burst_cnt <= '0;
                  busy      <= 1'b1;
               end
            end
            ST_GRANT: begin
               if (!g_valid) begin
                  state  <= ST_IDLE;
                  busy   <= 1'b0;
                  rr_ptr <= next_ptr;
               end else if (accept) begin
                  if (burst_done) begin
                     state     <= ST_IDLE;
                     busy      <= 1'b0;
                     rr_ptr    <= next_ptr;
                     burst_cnt <= '0;
                  end else begin
                     burst_cnt <= burst_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_fifo_wr_arbiter.sv
// Testbench for axi_fifo_wr_arbiter: per-channel producers feed queued words,
// expected words are queued at issue time and a negedge monitor pops and compares
// every FIFO write. Directed scenarios additionally check write timing and channel order.
module tb_axi_fifo_wr_arbiter;

   localparam int N_CH = 4;
   localparam int DW   = 32;
   localparam int BL   = 4;
   localparam int CH_W = 2;

   logic                 aclk = 1'b0;
   logic                 aresetn;
   logic [N_CH-1:0]      s_valid;
   logic [N_CH*DW-1:0]   s_data;
   logic [N_CH-1:0]      s_ready;
   logic [DW-1:0]        fifo_wr_data;
   logic                 fifo_wr_en;
   logic [CH_W-1:0]      fifo_wr_ch;
   logic                 fifo_full;
   logic                 busy;
   logic [CH_W-1:0]      grant_ch;

   axi_fifo_wr_arbiter #(.N_CH(N_CH), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_ready      (s_ready),
      .fifo_wr_data (fifo_wr_data),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_ch   (fifo_wr_ch),
      .fifo_full    (fifo_full),
      .busy         (busy),
      .grant_ch     (grant_ch)
   );

   always #5 aclk = ~aclk;

   logic [DW-1:0]   send_q[N_CH][$];
   logic [DW-1:0]   exp_q[N_CH][$];
   int              wr_ch_q[$];
   int              wr_cyc_q[$];
   int              n_cmp = 0;
   int              n_bad = 0;
   int              cyc   = 0;
   logic [N_CH-1:0] hs    = '0;
   logic            rand_mode = 1'b0;
   logic            full_req  = 1'b0;
   logic [DW-1:0]   exp_word;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge aclk);
      #3;
   endtask

   task automatic push(input int ch, input logic [DW-1:0] w);
      send_q[ch].push_back(w);
      exp_q[ch].push_back(w);
   endtask

   task automatic clear_log();
      wr_ch_q.delete();
      wr_cyc_q.delete();
   endtask

   function automatic bit pending();
      for (int i = 0; i < N_CH; i++)
         if (send_q[i].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drain(input int limit);
      int n;
      n = 0;
      while (pending() && n < limit) begin
         step(1);
         n++;
      end
      if (pending()) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: words still queued after %0d cycles, want none", limit);
         for (int i = 0; i < N_CH; i++) begin
            send_q[i].delete();
            exp_q[i].delete();
         end
      end
      step(4);
   endtask

   task automatic chk_wr(input string name, input int k, input int ch, input int c);
      if (k >= wr_ch_q.size()) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: write #%0d missing (only %0d), want ch %0d at cycle %0d",
                  name, k, wr_ch_q.size(), ch, c);
      end else begin
         chk({name, "_ch"}, wr_ch_q[k], ch);
         chk({name, "_cyc"}, wr_cyc_q[k], c);
      end
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      step(2);
      aresetn = 1'b1;
      step(1);
      clear_log();
   endtask

   // Producers: retire accepted words, hold valid/data until accepted, present the next word.
   initial begin
      s_valid   = '0;
      s_data    = '0;
      fifo_full = 1'b0;
      forever begin
         @(posedge aclk);
         #1;
         for (int i = 0; i < N_CH; i++) begin
            if (hs[i] && send_q[i].size() > 0) send_q[i].delete(0);
            if (send_q[i].size() == 0)       s_valid[i] = 1'b0;
            else if (s_valid[i] && !hs[i])   s_valid[i] = 1'b1;
            else                             s_valid[i] = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data[i*DW +: DW] = (send_q[i].size() > 0) ? send_q[i][0] : '0;
         end
         fifo_full = rand_mode ? ($urandom_range(0, 3) == 0) : full_req;
      end
   end

   // Monitor: sample away from the active edge, score every FIFO write.
   initial begin
      forever begin
         @(negedge aclk);
         cyc++;
         hs = s_valid & s_ready;
         if (aresetn) begin
            chk("ready_onehot", 64'($countones(s_ready) <= 1), 64'd1);
            if (fifo_full) chk("full_no_write", 64'(fifo_wr_en), 64'd0);
            if (fifo_wr_en) begin
               wr_ch_q.push_back(int'(fifo_wr_ch));
               wr_cyc_q.push_back(cyc);
               if (exp_q[fifo_wr_ch].size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_write: ch %0d data 0x%0h, want no write", fifo_wr_ch, fifo_wr_data);
               end else begin
                  exp_word = exp_q[fifo_wr_ch].pop_front();
                  chk($sformatf("data_ch%0d", fifo_wr_ch), fifo_wr_data, exp_word);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int m;
      int pat[16] = '{1, 1, 1, 1, 3, 3, 3, 3, 1, 1, 1, 1, 3, 3, 3, 3};

      // Reset state
      aresetn = 1'b0;
      step(2);
      chk("rst_busy", busy, 0);
      chk("rst_grant_ch", grant_ch, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_wr_ch", fifo_wr_ch, 0);
      aresetn = 1'b1;
      step(1);
      clear_log();

      // 1: five back-to-back words on ch0, forced re-arbitration after four
      m = cyc + 1;
      for (int i = 0; i < 5; i++) push(0, 32'hA000_0000 + i);
      drain(200);
      for (int k = 0; k < 4; k++) chk_wr("t1_burst", k, 0, m + 2 + k);
      chk_wr("t1_after_bubble", 4, 0, m + 7);
      chk("t1_count", wr_ch_q.size(), 5);

      // 2: ch1 and ch3 streaming, bursts alternate
      do_reset();
      m = cyc + 1;
      for (int i = 0; i < 8; i++) begin
         push(1, 32'hB100_0000 + i);
         push(3, 32'hB300_0000 + i);
      end
      drain(300);
      chk("t2_count", wr_ch_q.size(), 16);
      for (int k = 0; k < 16; k++)
         if (k < wr_ch_q.size()) chk($sformatf("t2_order%0d", k), wr_ch_q[k], pat[k]);
      chk_wr("t2_first", 0, 1, m + 2);
      chk_wr("t2_switch", 4, 3, m + 7);

      // 3: ch2 stalled by fifo_full for 3 cycles after its 2nd word
      do_reset();
      m = cyc + 1;
      for (int i = 0; i < 4; i++) push(2, 32'hC200_0000 + i);
      step(3);
      full_req = 1'b1;
      step(1);
      chk("t3_ready_blocked", s_ready, 0);
      chk("t3_busy_held", busy, 1);
      step(2);
      full_req = 1'b0;
      drain(200);
      chk_wr("t3_w0", 0, 2, m + 2);
      chk_wr("t3_w1", 1, 2, m + 3);
      chk_wr("t3_w2", 2, 2, m + 7);
      chk_wr("t3_w3", 3, 2, m + 8);
      chk("t3_count", wr_ch_q.size(), 4);

      // 4: ch0 goes idle after 2 words, waiting ch1 takes over
      do_reset();
      m = cyc + 1;
      push(0, 32'hD000_0000);
      push(0, 32'hD000_0001);
      push(1, 32'hD100_0000);
      push(1, 32'hD100_0001);
      step(5);
      chk("t4_idle_busy", busy, 0);
      step(1);
      chk("t4_regrant_busy", busy, 1);
      chk("t4_regrant_ch", grant_ch, 1);
      drain(200);
      chk_wr("t4_a", 0, 0, m + 2);
      chk_wr("t4_b", 1, 0, m + 3);
      chk_wr("t4_c", 2, 1, m + 6);
      chk_wr("t4_d", 3, 1, m + 7);

      // 5: ch3 alone, then ch0 and ch3 together: pointer wrapped to 0 so ch0 first
      do_reset();
      m = cyc + 1;
      push(3, 32'hE300_0000);
      step(3);
      push(0, 32'hE000_0000);
      push(3, 32'hE300_0001);
      drain(200);
      chk_wr("t5_ch3", 0, 3, m + 2);
      chk_wr("t5_ch0", 1, 0, m + 5);
      chk_wr("t5_ch3b", 2, 3, m + 8);

      // 6: reset while ch1 presents its 2nd word
      do_reset();
      m = cyc + 1;
      for (int i = 0; i < 4; i++) push(1, 32'hF100_0000 + i);
      step(3);
      aresetn = 1'b0;
      step(1);
      chk("t6_busy", busy, 0);
      chk("t6_grant_ch", grant_ch, 0);
      chk("t6_s_ready", s_ready, 0);
      chk("t6_wr_en", fifo_wr_en, 0);
      chk("t6_wr_data", fifo_wr_data, 0);
      chk("t6_wr_ch", fifo_wr_ch, 0);
      push(0, 32'hF000_0000);
      push(0, 32'hF000_0001);
      step(1);
      aresetn = 1'b1;
      drain(200);
      chk_wr("t6_pre", 0, 1, m + 2);
      chk_wr("t6_ch0a", 1, 0, m + 6);
      chk_wr("t6_ch0b", 2, 0, m + 7);
      chk_wr("t6_ch1", 3, 1, m + 10);
      chk("t6_count", wr_ch_q.size(), 6);

      // Randomised valid/full patterns, all channels
      do_reset();
      rand_mode = 1'b1;
      for (int i = 0; i < 15; i++)
         for (int ch = 0; ch < N_CH; ch++)
            push(ch, 32'h5000_0000 | (ch << 16) | i);
      drain(4000);
      rand_mode = 1'b0;
      step(4);
      for (int ch = 0; ch < N_CH; ch++)
         chk($sformatf("rand_leftover_ch%0d", ch), exp_q[ch].size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
